// File: rtl/dcache_req_responder.sv
// Split-phase L1 dcache responder backed by a word-addressed memory; one operation in flight.
// Optional requester backpressure (LFSR-gated grants) under `DCACHE_RESP_BACKPRESSURE_EN.
module dcache_req_responder #(
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned TAG_WIDTH   = 44,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned LD_LATENCY  = 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   ld_req_valid_i,
    input  logic [INDEX_WIDTH-1:0] ld_req_addr_index_i,
    input  logic [1:0]             ld_req_size_i,
    input  logic                   ld_req_tag_valid_i,
    input  logic [TAG_WIDTH-1:0]   ld_req_addr_tag_i,
    input  logic                   ld_req_kill_i,
    output logic                   ld_req_gnt_o,
    input  logic                   st_req_valid_i,
    input  logic [INDEX_WIDTH-1:0] st_req_addr_index_i,
    input  logic [63:0]            st_req_wdata_i,
    input  logic [7:0]             st_req_be_i,
    input  logic [1:0]             st_req_size_i,
    input  logic                   st_req_tag_valid_i,
    input  logic [TAG_WIDTH-1:0]   st_req_addr_tag_i,
    input  logic                   st_req_kill_i,
    output logic                   st_req_gnt_o,
    output logic                   dmem_resp_valid_o,
    output logic [63:0]            dmem_resp_data_o,
    output logic                   dmem_resp_nack_o,
    output logic                   dmem_xcpt_ma_ld_o,
    output logic                   dmem_xcpt_ma_st_o
);
    localparam int unsigned PW = TAG_WIDTH + INDEX_WIDTH;
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = (LD_LATENCY > 2) ? $clog2(LD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, LD_TAG, ST_TAG, LD_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [1:0]             size_q;
    logic [63:0]            wdata_q;
    logic [7:0]             be_q;
    logic [63:0]            ld_word_q;
    logic                   cap_st, cap_ld, ld_rd, mem_we, hold;
    logic                   resp_valid_d, nack_d, ma_ld_d, ma_st_d;
    logic [63:0]            resp_data_d;

    logic [63:0]            mem [MEM_WORDS];
    logic [TAG_WIDTH-1:0]   tag;
    logic [PW-1:0]          paddr;
    logic [PW-4:0]          word;
    logic [AW-1:0]          widx;
    logic                   misaligned, out_of_range;
    logic [63:0]            mem_rd;

    assign tag          = (state_q == LD_TAG) ? ld_req_addr_tag_i : st_req_addr_tag_i;
    assign paddr        = {tag, idx_q};
    assign word         = paddr[PW-1:3];
    assign widx         = word[AW-1:0];
    assign out_of_range = (word >= (PW-3)'(MEM_WORDS));
    assign mem_rd       = mem[widx];

    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            2'd1:    misaligned = paddr[0];
            2'd2:    misaligned = (paddr[1:0] != 2'b00);
            2'd3:    misaligned = (paddr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

`ifdef DCACHE_RESP_BACKPRESSURE_EN
    logic [7:0] lfsr_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) lfsr_q <= 8'hA5;
        else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign hold = lfsr_q[0];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_st       = 1'b0;
        cap_ld       = 1'b0;
        ld_rd        = 1'b0;
        mem_we       = 1'b0;
        st_req_gnt_o = 1'b0;
        ld_req_gnt_o = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        nack_d       = 1'b0;
        ma_ld_d      = 1'b0;
        ma_st_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hold) begin
                    if (st_req_valid_i) begin
                        st_req_gnt_o = 1'b1;
                        cap_st       = 1'b1;
                        state_d      = ST_TAG;
                    end else if (ld_req_valid_i) begin
                        ld_req_gnt_o = 1'b1;
                        cap_ld       = 1'b1;
                        state_d      = LD_TAG;
                    end
                end
            end
            ST_TAG: begin
                if (st_req_kill_i) begin
                    state_d = IDLE;
                end else if (st_req_tag_valid_i) begin
                    state_d = IDLE;
                    if (misaligned)        ma_st_d = 1'b1;
                    else if (out_of_range) nack_d  = 1'b1;
                    else begin
                        mem_we       = 1'b1;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            LD_TAG: begin
                if (ld_req_kill_i) begin
                    state_d = IDLE;
                end else if (ld_req_tag_valid_i) begin
                    if (misaligned) begin
                        ma_ld_d = 1'b1;
                        state_d = IDLE;
                    end else if (out_of_range) begin
                        nack_d  = 1'b1;
                        state_d = IDLE;
                    end else if (LD_LATENCY == 1) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = mem_rd;
                        state_d      = IDLE;
                    end else begin
                        ld_rd   = 1'b1;
                        cnt_d   = CW'(LD_LATENCY - 1);
                        state_d = LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                // Pulse is registered, so it is launched on the edge where the count reaches 0.
                if (ld_req_kill_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CW'(1)) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = ld_word_q;
                    state_d      = IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            idx_q             <= '0;
            size_q            <= '0;
            wdata_q           <= '0;
            be_q              <= '0;
            ld_word_q         <= '0;
            dmem_resp_valid_o <= 1'b0;
            dmem_resp_data_o  <= '0;
            dmem_resp_nack_o  <= 1'b0;
            dmem_xcpt_ma_ld_o <= 1'b0;
            dmem_xcpt_ma_st_o <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            dmem_resp_valid_o <= resp_valid_d;
            dmem_resp_data_o  <= resp_data_d;
            dmem_resp_nack_o  <= nack_d;
            dmem_xcpt_ma_ld_o <= ma_ld_d;
            dmem_xcpt_ma_st_o <= ma_st_d;
            if (cap_st) begin
                idx_q   <= st_req_addr_index_i;
                size_q  <= st_req_size_i;
                wdata_q <= st_req_wdata_i;
                be_q    <= st_req_be_i;
            end else if (cap_ld) begin
                idx_q  <= ld_req_addr_index_i;
                size_q <= ld_req_size_i;
            end
            if (ld_rd) ld_word_q <= mem_rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (be_q[b]) mem[widx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dcache_req_responder.sv
// Randomized self-checking bench for dcache_req_responder against a flat memory/rule model.
module tb_dcache_req_responder;
    localparam int unsigned INDEX_WIDTH = 12;
    localparam int unsigned TAG_WIDTH   = 44;
    localparam int unsigned MEM_WORDS   = 1024;
    localparam int unsigned LD_LATENCY  = 2;
    localparam int unsigned PW          = TAG_WIDTH + INDEX_WIDTH;

    logic                   clk_i, rstn_i;
    logic                   ld_req_valid_i, ld_req_tag_valid_i, ld_req_kill_i, ld_req_gnt_o;
    logic [INDEX_WIDTH-1:0] ld_req_addr_index_i, st_req_addr_index_i;
    logic [1:0]             ld_req_size_i, st_req_size_i;
    logic [TAG_WIDTH-1:0]   ld_req_addr_tag_i, st_req_addr_tag_i;
    logic                   st_req_valid_i, st_req_tag_valid_i, st_req_kill_i, st_req_gnt_o;
    logic [63:0]            st_req_wdata_i, dmem_resp_data_o;
    logic [7:0]             st_req_be_i;
    logic                   dmem_resp_valid_o, dmem_resp_nack_o, dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o;

    dcache_req_responder #(
        .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH),
        .MEM_WORDS(MEM_WORDS), .LD_LATENCY(LD_LATENCY)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .ld_req_valid_i(ld_req_valid_i), .ld_req_addr_index_i(ld_req_addr_index_i),
        .ld_req_size_i(ld_req_size_i), .ld_req_tag_valid_i(ld_req_tag_valid_i),
        .ld_req_addr_tag_i(ld_req_addr_tag_i), .ld_req_kill_i(ld_req_kill_i),
        .ld_req_gnt_o(ld_req_gnt_o),
        .st_req_valid_i(st_req_valid_i), .st_req_addr_index_i(st_req_addr_index_i),
        .st_req_wdata_i(st_req_wdata_i), .st_req_be_i(st_req_be_i),
        .st_req_size_i(st_req_size_i), .st_req_tag_valid_i(st_req_tag_valid_i),
        .st_req_addr_tag_i(st_req_addr_tag_i), .st_req_kill_i(st_req_kill_i),
        .st_req_gnt_o(st_req_gnt_o),
        .dmem_resp_valid_o(dmem_resp_valid_o), .dmem_resp_data_o(dmem_resp_data_o),
        .dmem_resp_nack_o(dmem_resp_nack_o), .dmem_xcpt_ma_ld_o(dmem_xcpt_ma_ld_o),
        .dmem_xcpt_ma_st_o(dmem_xcpt_ma_st_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] ref_mem [MEM_WORDS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Index phase (waits for grant), then tag phase; returns 1ns after the tag-accept edge.
    task automatic issue(input bit st, input logic [PW-1:0] pa, input logic [63:0] wd,
                         input logic [7:0] be, input logic [1:0] sz, input bit tkill);
        int n;
        if (st) begin
            st_req_valid_i = 1'b1; st_req_addr_index_i = pa[INDEX_WIDTH-1:0];
            st_req_wdata_i = wd; st_req_be_i = be; st_req_size_i = sz;
        end else begin
            ld_req_valid_i = 1'b1; ld_req_addr_index_i = pa[INDEX_WIDTH-1:0];
            ld_req_size_i = sz;
        end
        #1;
        n = 0;
        while (!(st ? st_req_gnt_o : ld_req_gnt_o) && n < 64) begin
            @(posedge clk_i); #2;
            n++;
        end
        check(st ? "st_gnt" : "ld_gnt", st ? st_req_gnt_o : ld_req_gnt_o, 1);
`ifndef DCACHE_RESP_BACKPRESSURE_EN
        check("gnt_wait", n, 0);
`endif
        @(posedge clk_i); #1;
        st_req_valid_i = 1'b0; ld_req_valid_i = 1'b0;
        if (st) begin
            st_req_tag_valid_i = 1'b1; st_req_addr_tag_i = pa[PW-1:INDEX_WIDTH]; st_req_kill_i = tkill;
        end else begin
            ld_req_tag_valid_i = 1'b1; ld_req_addr_tag_i = pa[PW-1:INDEX_WIDTH]; ld_req_kill_i = tkill;
        end
        @(posedge clk_i); #1;
        st_req_tag_valid_i = 1'b0; ld_req_tag_valid_i = 1'b0;
        st_req_kill_i = 1'b0; ld_req_kill_i = 1'b0;
    endtask

    // Watch all pulse outputs for a few cycles after tag acceptance (cycle 1 = next cycle).
    task automatic window(input bit kill2, output int fr, output int fn, output int fml,
                          output int fms, output int pulses, output logic [63:0] rd);
        fr = 0; fn = 0; fml = 0; fms = 0; pulses = 0; rd = '0;
        for (int c = 1; c <= int'(LD_LATENCY) + 2; c++) begin
            if (dmem_resp_valid_o) begin if (fr == 0) fr = c; rd = dmem_resp_data_o; pulses++; end
            if (dmem_resp_nack_o)  begin if (fn == 0)  fn  = c; pulses++; end
            if (dmem_xcpt_ma_ld_o) begin if (fml == 0) fml = c; pulses++; end
            if (dmem_xcpt_ma_st_o) begin if (fms == 0) fms = c; pulses++; end
            if (kill2 && c == 1) ld_req_kill_i = 1'b1;
            @(posedge clk_i); #1;
            ld_req_kill_i = 1'b0;
        end
    endtask

    task automatic expect_op(input bit st, input logic [PW-1:0] pa, input logic [63:0] wd,
                             input logic [7:0] be, input logic [1:0] sz, input int km,
                             input int fr, input int fn, input int fml, input int fms,
                             input int pulses, input logic [63:0] rd);
        logic [PW-1:0] word;
        bit mis, oor;
        int w;
        word = pa >> 3;
        mis = (sz == 2'd1 && pa[0]) || (sz == 2'd2 && pa[1:0] != 2'b00) ||
              (sz == 2'd3 && pa[2:0] != 3'b000);
        oor = (word >= PW'(MEM_WORDS));
        w = int'(word[9:0]);
        if (km == 1) begin
            check("tagkill_pulses", pulses, 0);
        end else if (mis) begin
            check(st ? "ma_st_cycle" : "ma_ld_cycle", st ? fms : fml, 1);
            check("ma_pulses", pulses, 1);
        end else if (oor) begin
            check("nack_cycle", fn, 1);
            check("nack_pulses", pulses, 1);
        end else if (km == 2) begin
            check("ldkill_pulses", pulses, 0);
        end else begin
            check(st ? "st_resp_cycle" : "ld_resp_cycle", fr, st ? 1 : LD_LATENCY);
            check("resp_pulses", pulses, 1);
            if (st) begin
                check("st_data", rd, 64'd0);
                for (int b = 0; b < 8; b++)
                    if (be[b]) ref_mem[w][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                check("ld_data", rd, ref_mem[w]);
            end
        end
    endtask

    task automatic run_op(input bit st, input logic [PW-1:0] pa, input logic [63:0] wd,
                          input logic [7:0] be, input logic [1:0] sz, input int km);
        int fr, fn, fml, fms, p;
        logic [63:0] rd;
        issue(st, pa, wd, be, sz, km == 1);
        window(km == 2, fr, fn, fml, fms, p, rd);
        expect_op(st, pa, wd, be, sz, km, fr, fn, fml, fms, p, rd);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, dmem_resp_valid_o, 0);
        check({tag, "_data"},  dmem_resp_data_o, 0);
        check({tag, "_nack"},  dmem_resp_nack_o, 0);
        check({tag, "_ma_ld"}, dmem_xcpt_ma_ld_o, 0);
        check({tag, "_ma_st"}, dmem_xcpt_ma_st_o, 0);
    endtask

    initial begin
        int fr, fn, fml, fms, p, km;
        logic [63:0] rd, wd;
        logic [PW-1:0] pa, wordv;
        bit st;

        rstn_i = 1'b0;
        ld_req_valid_i = 0; ld_req_addr_index_i = '0; ld_req_size_i = '0;
        ld_req_tag_valid_i = 0; ld_req_addr_tag_i = '0; ld_req_kill_i = 0;
        st_req_valid_i = 0; st_req_addr_index_i = '0; st_req_wdata_i = '0; st_req_be_i = '0;
        st_req_size_i = '0; st_req_tag_valid_i = 0; st_req_addr_tag_i = '0; st_req_kill_i = 0;
        #2;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        for (int w = 0; w < 16; w++)
            run_op(1, PW'(w * 8), {$urandom, $urandom}, 8'hFF, 2'd3, 0);

        run_op(1, PW'('h40), 64'h1122334455667788, 8'hFF, 2'd3, 0);
        run_op(0, PW'('h40), '0, '0, 2'd3, 0);
        run_op(1, PW'('h43), 64'h00000000AB000000, 8'h08, 2'd0, 0);
        run_op(0, PW'('h40), '0, '0, 2'd3, 0);
        check("byte3_merge", ref_mem[8], 64'h11223344AB667788);

`ifndef DCACHE_RESP_BACKPRESSURE_EN
        // Store and load valid together: store wins, load granted on the store's response cycle.
        wd = 64'hCAFEF00D12345678;
        st_req_valid_i = 1; st_req_addr_index_i = 12'h048; st_req_wdata_i = wd;
        st_req_be_i = 8'hFF; st_req_size_i = 2'd3;
        ld_req_valid_i = 1; ld_req_addr_index_i = 12'h040; ld_req_size_i = 2'd3;
        #1;
        check("both_st_gnt", st_req_gnt_o, 1);
        check("both_ld_gnt", ld_req_gnt_o, 0);
        @(posedge clk_i); #1;
        st_req_valid_i = 0; st_req_tag_valid_i = 1; st_req_addr_tag_i = '0;
        check("ld_gnt_in_st_tag", ld_req_gnt_o, 0);
        @(posedge clk_i); #1;
        st_req_tag_valid_i = 0;
        check("both_st_resp", dmem_resp_valid_o, 1);
        check("ld_gnt_after_resp", ld_req_gnt_o, 1);
        ref_mem[9] = wd;
        @(posedge clk_i); #1;
        ld_req_valid_i = 0; ld_req_tag_valid_i = 1; ld_req_addr_tag_i = '0;
        @(posedge clk_i); #1;
        ld_req_tag_valid_i = 0;
        window(0, fr, fn, fml, fms, p, rd);
        expect_op(0, PW'('h40), '0, '0, 2'd3, 0, fr, fn, fml, fms, p, rd);
        run_op(0, PW'('h48), '0, '0, 2'd3, 0);
`endif

        run_op(0, PW'('h41), '0, '0, 2'd1, 0);
        run_op(0, PW'('h2000), '0, '0, 2'd3, 0);
        run_op(0, PW'('h41), '0, '0, 2'd3, 0);
        run_op(1, PW'('h2004), 64'h1, 8'hFF, 2'd2, 0);
        run_op(0, PW'('h40), '0, '0, 2'd3, 2);
        run_op(0, PW'('h40), '0, '0, 2'd3, 0);
        run_op(1, PW'('h40), 64'hDEAD, 8'hFF, 2'd3, 1);
        run_op(0, PW'('h40), '0, '0, 2'd3, 0);

        // Reset during LD_WAIT: nothing pending survives.
        issue(0, PW'('h40), '0, '0, 2'd3, 0);
        rstn_i = 1'b0;
        #1;
        check_outputs_zero("rst_ldwait");
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        window(0, fr, fn, fml, fms, p, rd);
        check("rst_ldwait_no_pulse", p, 0);
        run_op(0, PW'('h40), '0, '0, 2'd3, 0);

        // Reset while a store response pulse is visible clears it immediately.
        wd = 64'h0123456789ABCDEF;
        issue(1, PW'('h50), wd, 8'hFF, 2'd3, 0);
        check("rst_pulse_pre", dmem_resp_valid_o, 1);
        ref_mem[10] = wd;
        rstn_i = 1'b0;
        #1;
        check_outputs_zero("rst_pulse");
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        run_op(0, PW'('h50), '0, '0, 2'd3, 0);

        for (int i = 0; i < 200; i++) begin
            st = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) wordv = PW'(MEM_WORDS + $urandom_range(0, 4095));
            else                           wordv = PW'($urandom_range(0, 15));
            pa = (wordv << 3) | PW'($urandom_range(0, 7));
            km = 0;
            case ($urandom_range(0, 9))
                0:       km = 1;
                1:       km = (!st && LD_LATENCY > 1) ? 2 : 0;
                default: km = 0;
            endcase
            run_op(st, pa, {$urandom, $urandom}, 8'($urandom), 2'($urandom), km);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dcache_req_responder.md
Name: dcache_req_responder

Overview:
- Responder/slave end of the split-phase L1 data-cache request interface driven by the core's dcache adapter (separate load and store request ports, index phase then tag phase, kill, response valid/nack/misalign).
- Backed by a word-addressed internal memory; used as the dcache stand-in for core-level simulation and FPGA bring-up, and as the protocol reference for the real cache.
- One operation in flight; fixed, parameterised load latency.

Parameters:
- INDEX_WIDTH, 12, width of addr_index (low paddr bits, includes byte offset)
- TAG_WIDTH, 44, width of addr_tag (high paddr bits)
- MEM_WORDS, 1024, number of 64-bit words in backing store (power of two)
- LD_LATENCY, 2, cycles from accepted tag phase to load response (>=1)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- ld_req_valid_i  in  1  load index phase valid
- ld_req_addr_index_i  in  INDEX_WIDTH  load index
- ld_req_size_i  in  2  0=B, 1=H, 2=W, 3=D
- ld_req_tag_valid_i  in  1  load tag phase valid
- ld_req_addr_tag_i  in  TAG_WIDTH  load tag
- ld_req_kill_i  in  1  abort load
- ld_req_gnt_o  out  1  load index accepted
- st_req_valid_i  in  1  store index phase valid
- st_req_addr_index_i  in  INDEX_WIDTH  store index
- st_req_wdata_i  in  64  store data, lane-aligned
- st_req_be_i  in  8  byte enables
- st_req_size_i  in  2  store size
- st_req_tag_valid_i  in  1  store tag phase valid
- st_req_addr_tag_i  in  TAG_WIDTH  store tag
- st_req_kill_i  in  1  abort store
- st_req_gnt_o  out  1  store index accepted
- dmem_resp_valid_o  out  1  response pulse
- dmem_resp_data_o  out  64  raw 64-bit word (extension done by the core)
- dmem_resp_nack_o  out  1  request rejected (out of range)
- dmem_xcpt_ma_ld_o  out  1  misaligned load pulse
- dmem_xcpt_ma_st_o  out  1  misaligned store pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0. Memory contents are not reset. Async reset mid-operation drops any pending access or response.
- FSM states: IDLE, LD_TAG, ST_TAG, LD_WAIT.
- IDLE:
  - st_req_valid_i=1: st_req_gnt_o=1 for one cycle; capture index, wdata, be, size; go to ST_TAG.
  - Otherwise, if ld_req_valid_i=1: ld_req_gnt_o=1 for one cycle; capture index, size; go to LD_TAG.
  - If both are valid, the store wins. The load sees gnt=0 and must hold valid.
  - gnt is never asserted outside IDLE.
- Address handling:
  - paddr = {tag, index}; word = paddr>>3.
  - Misaligned: size1 & paddr[0]; size2 & paddr[1:0]!=0; size3 & paddr[2:0]!=0.
  - Out of range: word >= MEM_WORDS.
- ST_TAG:
  - Kill (with or without tag_valid): go to IDLE, no write, no outputs.
  - tag_valid with misaligned address: dmem_xcpt_ma_st_o pulse next cycle, no write, go to IDLE.
  - tag_valid, aligned, out of range: dmem_resp_nack_o pulse next cycle, no write, go to IDLE.
  - tag_valid otherwise: write bytes where be=1, then dmem_resp_valid_o pulse next cycle with data=0, go to IDLE.
  - Misalign takes priority over nack.
- LD_TAG:
  - Same kill, misalign (dmem_xcpt_ma_ld_o) and nack rules as ST_TAG.
  - Otherwise load counter with LD_LATENCY-1 and go to LD_WAIT; if LD_LATENCY=1, respond directly.
- LD_WAIT:
  - Decrement the counter each cycle. At 0: dmem_resp_valid_o=1 for one cycle, data=mem[word] read at tag acceptance, go to IDLE.
  - ld_req_kill_i at any cycle in LD_WAIT suppresses the response and returns to IDLE.
- Response timing: a load tag accepted at cycle T responds at T+LD_LATENCY. All response/xcpt/nack outputs are single-cycle pulses and mutually exclusive.
- Back-to-back: a new index phase may be granted the cycle after a response pulse; same-cycle response and new gnt is allowed (IDLE entered on the pulse cycle).

Optional Feature:
- DCACHE_RESP_BACKPRESSURE_EN defined:
  - An 8-bit LFSR (seed 8'hA5 at reset, taps 8,6,5,4) advances every cycle.
  - In IDLE, lfsr[0]=1 withholds both gnts that cycle (state unchanged).
  - Stresses requester hold-valid behaviour.
- Not defined: grant in the first IDLE cycle with a valid request; no LFSR logic.

Test Plan:
- Store to paddr 0x40 with wdata 0x1122334455667788 and be=8'hFF, then load D from 0x40 -> store resp_valid pulse with data 0; load resp_valid exactly 2 cycles after tag_valid with data 0x1122334455667788.
- Store B to 0x43 with be=8'h08 and data 0xAB<<24, then load D from 0x40 -> byte 3 = 0xAB, other bytes unchanged.
- st_req_valid and ld_req_valid asserted in the same cycle -> st_gnt=1, ld_gnt=0; load granted in the first IDLE cycle after the store response.
- Load H from 0x41 -> dmem_xcpt_ma_ld_o pulse, no resp_valid. Load D from word MEM_WORDS (0x2000) -> nack pulse, no resp_valid.
- Load tag accepted, then ld_req_kill_i in LD_WAIT -> no resp_valid, and the next request is granted.
- Reset asserted during LD_WAIT -> all outputs 0 immediately; FSM is IDLE after release.
